// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the accelerator's master adapter and the register slave.
// Modports give each side its own view of the five channels.
interface axi_lite_reg_slave_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: N_REGS-1 byte-writable control words plus one read-only status word.
// Independent AW/W holding registers; one write and one read outstanding, running concurrently.
module axi_lite_reg_slave #(
    parameter int unsigned N_REGS = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    axi_lite_reg_slave_if.slave         axi,
    output logic [(N_REGS-1)*32-1:0]    regs_out,
    output logic [N_REGS-2:0]           reg_wr_pulse,
    input  logic [31:0]                 status_in
);
    localparam int unsigned NumRw      = N_REGS - 1;
    localparam logic [29:0] StatusIdx  = 30'(N_REGS - 1);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    logic [NumRw-1:0][31:0] regs_q, regs_d;
    logic [NumRw-1:0]       pulse_q, pulse_d;

    logic        aw_held_q, w_held_q;
    logic [29:0] aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [29:0] wr_idx, rd_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    // Byte offset within a word carries no meaning for a word-wide register bank.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.awaddr[1:0], axi.araddr[1:0]};

    assign axi.awready = !aw_held_q && !bvalid_q;
    assign axi.wready  = !w_held_q && !bvalid_q;
    assign axi.arready = !rvalid_q;

    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    // Payloads come from the holding registers if already captured, else straight off the bus.
    assign wr_idx  = aw_held_q ? aw_idx_q : axi.awaddr[31:2];
    assign wr_data = w_held_q ? wdata_q : axi.wdata;
    assign wr_strb = w_held_q ? wstrb_q : axi.wstrb;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign rd_idx  = axi.araddr[31:2];

    always_comb begin
        regs_d   = regs_q;
        pulse_d  = '0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (bvalid_q && axi.bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_idx < StatusIdx) ? RespOkay : RespSlvErr;
            for (int unsigned k = 0; k < NumRw; k++) begin
                if (wr_idx == 30'(k)) begin
                    pulse_d[k] = 1'b1;
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read data comes from regs_q, so a same-edge write is not visible to this read.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && axi.rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RespSlvErr;
            if (rd_idx == StatusIdx) begin
                rdata_d = status_in;
                rresp_d = RespOkay;
            end
            for (int unsigned k = 0; k < NumRw; k++) begin
                if (rd_idx == 30'(k)) begin
                    rdata_d = regs_q[k];
                    rresp_d = RespOkay;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_q    <= '0;
            pulse_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            regs_q   <= regs_d;
            pulse_q  <= pulse_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_held_q <= 1'b1;
                if (w_hs)  w_held_q  <= 1'b1;
            end
            if (aw_hs) begin
                aw_idx_q <= axi.awaddr[31:2];
            end
            if (w_hs) begin
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb;
            end
        end
    end

    assign axi.bvalid   = bvalid_q;
    assign axi.bresp    = bresp_q;
    assign axi.rvalid   = rvalid_q;
    assign axi.rdata    = rdata_q;
    assign axi.rresp    = rresp_q;
    assign regs_out     = regs_q;
    assign reg_wr_pulse = pulse_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: stimulus pushes expected B/R responses from an
// array-based register model; a negedge monitor pops and compares as the DUT presents them.
module tb_axi_lite_reg_slave;
    localparam int unsigned N       = 8;
    localparam int unsigned W       = (N - 1) * 32;
    localparam int unsigned Timeout = 50;

    typedef struct {
        logic [1:0]   resp;
        logic [N-2:0] pulse;
        logic [W-1:0] regs;
    } b_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic           clk;
    logic           resetn;
    logic [W-1:0]   regs_out;
    logic [N-2:0]   reg_wr_pulse;
    logic [31:0]    status;

    axi_lite_reg_slave_if bus ();

    axi_lite_reg_slave #(.N_REGS(N)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .axi          (bus),
        .regs_out     (regs_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_in    (status)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [31:0] model_regs [N-1];
    b_exp_t      exp_b [$];
    r_exp_t      exp_r [$];
    bit          aw_ok, w_ok;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no response, required a response", name);
    endfunction

    function automatic void push_write_exp(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [3:0] strb);
        b_exp_t      e;
        int unsigned idx;
        idx     = 32'(addr[31:2]);
        e.resp  = 2'b10;
        e.pulse = '0;
        if (addr[31:2] < 30'(N - 1)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
            end
            e.pulse[idx] = 1'b1;
            e.resp       = 2'b00;
        end
        for (int k = 0; k < N - 1; k++) e.regs[32*k +: 32] = model_regs[k];
        exp_b.push_back(e);
    endfunction

    function automatic void push_read_exp(input logic [31:0] addr);
        r_exp_t e;
        if (addr[31:2] < 30'(N - 1)) begin
            e.data = model_regs[32'(addr[31:2])];
            e.resp = 2'b00;
        end else if (addr[31:2] == 30'(N - 1)) begin
            e.data = status;
            e.resp = 2'b00;
        end else begin
            e.data = '0;
            e.resp = 2'b10;
        end
        exp_r.push_back(e);
    endfunction

    task automatic wait_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_aw(input logic [31:0] addr, input int unsigned dly, output bit ok);
        int unsigned cnt = 0;
        wait_cycles(dly);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        while (!bus.awready && cnt < Timeout) begin
            wait_cycles(1);
            cnt++;
        end
        ok = bus.awready;
        if (ok) begin
            wait_cycles(1);
            chk("awready_after_hs", W'(bus.awready), W'(1'b0));
        end else begin
            fail("aw_timeout");
        end
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb,
                          input int unsigned dly, output bit ok);
        int unsigned cnt = 0;
        wait_cycles(dly);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        while (!bus.wready && cnt < Timeout) begin
            wait_cycles(1);
            cnt++;
        end
        ok = bus.wready;
        if (ok) begin
            wait_cycles(1);
            chk("wready_after_hs", W'(bus.wready), W'(1'b0));
        end else begin
            fail("w_timeout");
        end
        bus.wvalid = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int unsigned aw_dly,
                               input int unsigned w_dly, input int unsigned b_dly);
        fork
            send_aw(addr, aw_dly, aw_ok);
            send_w(data, strb, w_dly, w_ok);
        join
        if (aw_ok && w_ok) begin
            // BVALID must be up in the cycle right after the later of the two handshakes.
            chk("b_latency", W'(bus.bvalid), W'(1'b1));
            wait_cycles(b_dly);
            bus.bready = 1'b1;
            wait_cycles(1);
            bus.bready = 1'b0;
            chk("bvalid_clear", W'(bus.bvalid), W'(1'b0));
        end
    endtask

    task automatic drive_read(input logic [31:0] addr, input int unsigned r_dly);
        int unsigned cnt = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!bus.arready && cnt < Timeout) begin
            wait_cycles(1);
            cnt++;
        end
        if (bus.arready) begin
            wait_cycles(1);
            bus.arvalid = 1'b0;
            chk("r_latency", W'(bus.rvalid), W'(1'b1));
            wait_cycles(r_dly);
            bus.rready = 1'b1;
            wait_cycles(1);
            bus.rready = 1'b0;
            chk("rvalid_clear", W'(bus.rvalid), W'(1'b0));
        end else begin
            bus.arvalid = 1'b0;
            fail("ar_timeout");
        end
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int unsigned aw_dly,
                             input int unsigned w_dly, input int unsigned b_dly);
        push_write_exp(addr, data, strb);
        drive_write(addr, data, strb, aw_dly, w_dly, b_dly);
    endtask

    task automatic read_txn(input logic [31:0] addr, input int unsigned r_dly);
        push_read_exp(addr);
        drive_read(addr, r_dly);
    endtask

    task automatic check_reset_state();
        chk("rst_awready", W'(bus.awready), W'(1'b1));
        chk("rst_wready", W'(bus.wready), W'(1'b1));
        chk("rst_arready", W'(bus.arready), W'(1'b1));
        chk("rst_bvalid", W'(bus.bvalid), W'(1'b0));
        chk("rst_rvalid", W'(bus.rvalid), W'(1'b0));
        chk("rst_bresp", W'(bus.bresp), W'(2'b00));
        chk("rst_rresp", W'(bus.rresp), W'(2'b00));
        chk("rst_rdata", W'(bus.rdata), W'(32'h0));
        chk("rst_pulse", W'(reg_wr_pulse), W'(1'b0));
        chk("rst_regs_out", regs_out, W'(1'b0));
    endtask

    // Monitor: pops an expectation on each rising BVALID/RVALID, checks holds while stalled.
    initial begin
        bit          b_prev = 1'b0;
        bit          r_prev = 1'b0;
        logic [1:0]  cur_bresp = '0;
        logic [31:0] cur_rdata = '0;
        logic [1:0]  cur_rresp = '0;
        b_exp_t      be;
        r_exp_t      re;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                b_prev = 1'b0;
                r_prev = 1'b0;
            end else begin
                if (bus.bvalid && !b_prev) begin
                    if (exp_b.size() == 0) begin
                        fail("b_unexpected");
                    end else begin
                        be = exp_b.pop_front();
                        chk("bresp", W'(bus.bresp), W'(be.resp));
                        chk("wr_pulse", W'(reg_wr_pulse), W'(be.pulse));
                        chk("regs_out", regs_out, be.regs);
                        cur_bresp = be.resp;
                    end
                end else begin
                    chk("pulse_idle", W'(reg_wr_pulse), W'(1'b0));
                    if (bus.bvalid) begin
                        chk("bresp_hold", W'(bus.bresp), W'(cur_bresp));
                        chk("awready_busy", W'(bus.awready), W'(1'b0));
                        chk("wready_busy", W'(bus.wready), W'(1'b0));
                    end
                end
                if (bus.rvalid && !r_prev) begin
                    if (exp_r.size() == 0) begin
                        fail("r_unexpected");
                    end else begin
                        re = exp_r.pop_front();
                        chk("rdata", W'(bus.rdata), W'(re.data));
                        chk("rresp", W'(bus.rresp), W'(re.resp));
                        cur_rdata = re.data;
                        cur_rresp = re.resp;
                    end
                end else if (bus.rvalid) begin
                    chk("rdata_hold", W'(bus.rdata), W'(cur_rdata));
                    chk("rresp_hold", W'(bus.rresp), W'(cur_rresp));
                    chk("arready_busy", W'(bus.arready), W'(1'b0));
                end
                b_prev = bus.bvalid;
                r_prev = bus.rvalid;
            end
        end
    end

    initial begin
        logic [31:0] addr, raddr, data;
        logic [3:0]  strb;
        resetn      = 1'b0;
        status      = '0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        foreach (model_regs[k]) model_regs[k] = '0;

        wait_cycles(2);
        check_reset_state();
        @(posedge clk);
        #2 resetn = 1'b1;
        wait_cycles(1);

        // Basic write then read back.
        write_txn(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        read_txn(32'h04, 0);

        // Byte strobes.
        write_txn(32'h00, 32'h11223344, 4'hF, 0, 0, 0);
        write_txn(32'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        read_txn(32'h00, 0);

        // W three cycles ahead of AW, then the reverse order.
        write_txn(32'h08, 32'h0BADF00D, 4'hF, 3, 0, 0);
        write_txn(32'h0C, 32'h12345678, 4'hF, 0, 2, 0);
        read_txn(32'h08, 0);

        // Backpressure on both response channels.
        write_txn(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 5);
        read_txn(32'h10, 5);

        // Status write, out-of-range read, status read, zero strobe.
        write_txn(32'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        read_txn(32'h40, 0);
        status = 32'h00000005;
        read_txn(32'h1C, 0);
        write_txn(32'h05, 32'hFFFFFFFF, 4'h0, 0, 0, 1);

        // Read and write of the same word on the same edge sees the old value.
        push_read_exp(32'h04);
        push_write_exp(32'h04, 32'h600DCAFE, 4'hF);
        fork
            drive_read(32'h04, 1);
            drive_write(32'h04, 32'h600DCAFE, 4'hF, 0, 0, 0);
        join
        read_txn(32'h04, 0);

        // Reset after AW handshake, before W.
        chk("aw_pre_reset", W'(bus.awready), W'(1'b1));
        bus.awaddr  = 32'h08;
        bus.awvalid = 1'b1;
        wait_cycles(1);
        bus.awvalid = 1'b0;
        #2 resetn = 1'b0;
        #1 check_reset_state();
        foreach (model_regs[k]) model_regs[k] = '0;
        @(posedge clk);
        #2 resetn = 1'b1;
        wait_cycles(1);
        write_txn(32'h0C, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        read_txn(32'h0C, 0);
        read_txn(32'h08, 0);

        // Randomized mix of writes, reads and concurrent pairs.
        for (int i = 0; i < 60; i++) begin
            addr = (32'($urandom_range(0, N + 1)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr[31] = 1'b1;
            raddr = (32'($urandom_range(0, N + 1)) << 2) | 32'($urandom_range(0, 3));
            data = $urandom;
            strb = 4'($urandom);
            if ($urandom_range(0, 5) == 0) strb = 4'h0;
            status = $urandom;
            case ($urandom_range(0, 2))
                0: write_txn(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 2));
                1: read_txn(raddr, $urandom_range(0, 2));
                default: begin
                    push_read_exp(raddr);
                    push_write_exp(addr, data, strb);
                    fork
                        drive_read(raddr, $urandom_range(0, 2));
                        drive_write(addr, data, strb, 0, 0, $urandom_range(0, 2));
                    join
                end
            endcase
        end

        wait_cycles(3);
        chk("b_queue_drained", W'(exp_b.size()), W'(0));
        chk("r_queue_drained", W'(exp_r.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
